// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one load/store on the data bus, waits for ack, forwards the raw word to asm.
// Define MEM_STAGE_TIMEOUT_EN to abort a bus access that is not acknowledged within TIMEOUT_CYCLES.
package core;

  typedef struct packed {
    logic [31:0] de_inst;
    logic [31:0] pc;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] ex_result;
    logic [31:0] ex_addr;
    logic        valid;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] de_inst;
    logic [31:0] pc;
    logic [31:0] ex_result;
    logic [31:0] ex_addr;
    logic [31:0] mem_result;
    logic        valid;
  } mem_asm_t;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [2:0]  F3_BYTE   = 3'b000;
  localparam logic [2:0]  F3_HALF   = 3'b001;

  localparam mem_asm_t mem_asm_rst = '{
    de_inst:    INST_NOP,
    pc:         32'h0,
    ex_result:  32'h0,
    ex_addr:    32'h0,
    mem_result: 32'h0,
    valid:      1'b0
  };

endpackage

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           next_rdy,
  input  core::ex_mem_t  ex_mem,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [31:0]    dmem_addr,
  output logic [31:0]    dmem_wdata,
  output logic [3:0]     dmem_be,
  input  logic           dmem_ack,
  input  logic [31:0]    dmem_rdata,
  output core::mem_asm_t mem_asm,
  output logic           mem_err,
  output logic           rdy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  core::ex_mem_t  op_q, op_d;
  logic [31:0]    rdata_q, rdata_d;
  core::mem_asm_t mem_asm_q, mem_asm_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     be_q, be_d;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Decode of the incoming op; bus fields are computed here and latched on accept.
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [1:0]  in_off;
  logic        in_is_store;
  logic        in_is_mem;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [31:0] load_word;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    in_opcode   = ex_mem.de_inst[6:0];
    in_funct3   = ex_mem.de_inst[14:12];
    in_off      = ex_mem.ex_addr[1:0];
    in_is_store = (in_opcode == core::OPC_STORE);
    in_is_mem   = in_is_store || (in_opcode == core::OPC_LOAD);
    in_wdata    = ex_mem.rs2_value << {in_off, 3'b000};
    in_be       = 4'b1111;
    if (in_is_store) begin
      case (in_funct3)
        core::F3_BYTE: in_be = 4'b0001 << in_off;
        core::F3_HALF: in_be = 4'b0011 << {in_off[1], 1'b0};
        default:       in_be = 4'b1111;
      endcase
    end
  end

  // Stores report a zero result; loads forward the raw bus word untouched.
  assign load_word = we_q ? 32'h0 : dmem_rdata;

  function automatic core::mem_asm_t to_asm(input core::ex_mem_t e,
                                            input logic [31:0]   result,
                                            input logic          v);
    core::mem_asm_t a;
    a.de_inst    = e.de_inst;
    a.pc         = e.pc;
    a.ex_result  = e.ex_result;
    a.ex_addr    = e.ex_addr;
    a.mem_result = result;
    a.valid      = v;
    return a;
  endfunction

  assign rdy = en && next_rdy && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rdata_d   = rdata_q;
    mem_asm_d = mem_asm_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rdy && ex_mem.valid && in_is_mem) begin
          state_d         = ST_BUSY;
          op_d            = ex_mem;
          we_d            = in_is_store;
          addr_d          = {ex_mem.ex_addr[31:2], 2'b00};
          wdata_d         = in_wdata;
          be_d            = in_be;
          mem_asm_d.valid = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end else if (next_rdy) begin
          mem_asm_d = to_asm(ex_mem, 32'h0, en && ex_mem.valid);
        end
      end

      ST_BUSY: begin
        if (dmem_ack) begin
          rdata_d = load_word;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (next_rdy) begin
            mem_asm_d = to_asm(op_q, load_word, 1'b1);
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_DONE;
          end
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        // An ack on the last allowed cycle is taken above, so it always beats the abort.
        else if (cnt_q == CNT_LAST) begin
          state_d         = ST_IDLE;
          mem_asm_d.valid = 1'b0;
          err_d           = 1'b1;
          we_d            = 1'b0;
          be_d            = 4'b0000;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        if (next_rdy) begin
          mem_asm_d = to_asm(op_q, rdata_q, 1'b1);
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rdata_q   <= 32'h0;
      mem_asm_q <= core::mem_asm_rst;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rdata_q   <= rdata_d;
      mem_asm_q <= mem_asm_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign dmem_req   = (state_q == ST_BUSY);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign mem_asm    = mem_asm_q;

  // Fields carried in the pipeline register that this stage has no use for.
  logic unused_ok;
  assign unused_ok = ^{ex_mem.rs1_value, op_q.rs1_value, op_q.rs2_value, op_q.valid,
                       (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the stage; also builds
// with MEM_STAGE_TIMEOUT_EN to cover the bus-timeout abort.
module tb_mem_stage;
  import core::*;

  localparam int TIMEOUT = 16;
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [6:0] OP_ALU = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;

  logic        clk = 1'b0;
  logic        rst, en, next_rdy, dmem_ack;
  ex_mem_t     ex_mem;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, mem_err, rdy;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  mem_asm_t    mem_asm;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .next_rdy   (next_rdy),
    .ex_mem     (ex_mem),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mem_asm    (mem_asm),
    .mem_err    (mem_err),
    .rdy        (rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: an op is either on the bus, parked with its data, or absent.
  bit          m_on_bus;
  bit          m_parked;
  ex_mem_t     m_op;
  logic [31:0] m_word;
  mem_asm_t    m_asm;
  bit          m_err;
  int          m_wait;

  function automatic mem_asm_t asm_reset();
    mem_asm_t a;
    a = '0;
    a.de_inst = 32'h0000_0013;
    return a;
  endfunction

  function automatic bit is_store(input ex_mem_t e);
    return e.de_inst[6:0] == OP_ST;
  endfunction

  function automatic bit is_load(input ex_mem_t e);
    return e.de_inst[6:0] == OP_LD;
  endfunction

  function automatic logic [31:0] exp_addr(input ex_mem_t e);
    return e.ex_addr - (e.ex_addr % 4);
  endfunction

  function automatic logic [3:0] exp_be(input ex_mem_t e);
    int off;
    off = int'(e.ex_addr % 4);
    if (!is_store(e)) return 4'd15;
    case (e.de_inst[14:12])
      3'd0:    return 4'(1 << off);
      3'd1:    return 4'(3 << (off - off % 2));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input ex_mem_t e);
    logic [63:0] w;
    w = {32'h0, e.rs2_value} << (8 * int'(e.ex_addr % 4));
    return w[31:0];
  endfunction

  function automatic mem_asm_t to_asm(input ex_mem_t e, input logic [31:0] res, input logic v);
    mem_asm_t a;
    a.de_inst    = e.de_inst;
    a.pc         = e.pc;
    a.ex_result  = e.ex_result;
    a.ex_addr    = e.ex_addr;
    a.mem_result = res;
    a.valid      = v;
    return a;
  endfunction

  function automatic ex_mem_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] res);
    ex_mem_t e;
    e.de_inst   = {17'h0, f3, 5'd1, opc};
    e.pc        = 32'h0000_0400;
    e.rs1_value = 32'h0;
    e.rs2_value = rs2;
    e.ex_result = res;
    e.ex_addr   = addr;
    e.valid     = 1'b1;
    return e;
  endfunction

  function automatic ex_mem_t rand_op();
    ex_mem_t     e;
    int          kind;
    logic [2:0]  f3;
    logic [6:0]  opc;
    kind = $urandom_range(0, 9);
    if (kind < 4) begin
      opc = (kind < 2) ? OP_ALU : OP_REG;
      f3  = 3'($urandom_range(0, 7));
    end else if (kind < 7) begin
      opc = OP_LD;
      f3  = 3'($urandom_range(0, 4));
      if (f3 == 3'd3) f3 = 3'd5;
    end else begin
      opc = OP_ST;
      f3  = 3'($urandom_range(0, 2));
    end
    e = mk(opc, f3, $urandom, $urandom, $urandom);
    e.pc        = $urandom;
    e.rs1_value = $urandom;
    e.valid     = ($urandom_range(0, 99) < 85);
    return e;
  endfunction

  task automatic model_reset();
    m_on_bus = 1'b0;
    m_parked = 1'b0;
    m_op     = '0;
    m_word   = 32'h0;
    m_asm    = asm_reset();
    m_err    = 1'b0;
    m_wait   = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_err = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!m_on_bus && !m_parked) begin
      if (en && next_rdy && ex_mem.valid && (is_load(ex_mem) || is_store(ex_mem))) begin
        m_op        = ex_mem;
        m_on_bus    = 1'b1;
        m_wait      = 0;
        m_asm.valid = 1'b0;
      end else if (next_rdy) begin
        m_asm = to_asm(ex_mem, 32'h0, en && ex_mem.valid);
      end
    end else if (m_on_bus) begin
      if (dmem_ack) begin
        m_word   = is_store(m_op) ? 32'h0 : dmem_rdata;
        m_on_bus = 1'b0;
        if (next_rdy) m_asm = to_asm(m_op, m_word, 1'b1);
        else          m_parked = 1'b1;
      end else begin
        m_wait++;
        if (TIMEOUT_ON && m_wait == TIMEOUT) begin
          m_on_bus    = 1'b0;
          m_asm.valid = 1'b0;
          m_err       = 1'b1;
        end
      end
    end else if (next_rdy) begin
      m_asm    = to_asm(m_op, m_word, 1'b1);
      m_parked = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("rdy", rdy, en && next_rdy && !m_on_bus && !m_parked);
    check("dmem_req", dmem_req, m_on_bus);
    if (m_on_bus) begin
      check("dmem_addr", dmem_addr, exp_addr(m_op));
      check("dmem_we", dmem_we, is_store(m_op));
      check("dmem_be", dmem_be, exp_be(m_op));
      check("dmem_wdata", dmem_wdata, exp_wdata(m_op));
    end
    check("mem_asm", mem_asm, m_asm);
    check("mem_err", mem_err, m_err);
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst        = 1'b0;
    en         = 1'b1;
    next_rdy   = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    ex_mem     = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst.dmem_req", dmem_req, 1'b0);
    check("rst.dmem_we", dmem_we, 1'b0);
    check("rst.dmem_be", dmem_be, 4'b0000);
    check("rst.mem_err", mem_err, 1'b0);
    check("rst.mem_asm", mem_asm, asm_reset());
    idle_inputs();

    // Non-memory op passes straight through with one cycle of latency.
    ex_mem = mk(OP_ALU, 3'd0, 32'h0, 32'h0, 32'h1234_5678);
    step();
    check("addi.valid", mem_asm.valid, 1'b1);
    check("addi.result", mem_asm.ex_result, 32'h1234_5678);
    check("addi.mem_result", mem_asm.mem_result, 32'h0);
    check("addi.req", dmem_req, 1'b0);

    // lw at an unaligned address, ack in the third bus cycle.
    ex_mem = mk(OP_LD, 3'd2, 32'h0000_1006, 32'h0, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    check("lw.bubble", mem_asm.valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("lw.addr", dmem_addr, 32'h0000_1004);
      check("lw.be", dmem_be, 4'b1111);
      check("lw.rdy", rdy, 1'b0);
      check("lw.req", dmem_req, 1'b1);
      step();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hAABB_CCDD;
    step();
    dmem_ack = 1'b0;
    check("lw.valid", mem_asm.valid, 1'b1);
    check("lw.result", mem_asm.mem_result, 32'hAABB_CCDD);
    check("lw.req_drop", dmem_req, 1'b0);

    // sb into the top byte lane.
    ex_mem = mk(OP_ST, 3'd0, 32'h0000_2003, 32'h0000_0012, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    check("sb.be", dmem_be, 4'b1000);
    check("sb.wdata", dmem_wdata, 32'h1200_0000);
    check("sb.we", dmem_we, 1'b1);
    check("sb.addr", dmem_addr, 32'h0000_2000);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0;
    check("sb.valid", mem_asm.valid, 1'b1);
    check("sb.result", mem_asm.mem_result, 32'h0);

    // lh acked while downstream stalls; result parks until next_rdy rises.
    ex_mem = mk(OP_LD, 3'd1, 32'h0000_3002, 32'h0, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    dmem_ack     = 1'b1;
    dmem_rdata   = 32'h5566_7788;
    next_rdy     = 1'b0;
    step();
    dmem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("lh.done_req", dmem_req, 1'b0);
      check("lh.held", mem_asm.valid, 1'b0);
      step();
    end
    next_rdy = 1'b1;
    step();
    check("lh.valid", mem_asm.valid, 1'b1);
    check("lh.result", mem_asm.mem_result, 32'h5566_7788);

    // Reset in the middle of a bus access abandons it.
    ex_mem = mk(OP_LD, 3'd2, 32'h0000_4000, 32'h0, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstbusy.req", dmem_req, 1'b0);
    check("rstbusy.asm", mem_asm, asm_reset());

    // Unacknowledged access: aborts after TIMEOUT cycles when enabled, waits otherwise.
    ex_mem = mk(OP_LD, 3'd2, 32'h0000_5000, 32'h0, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) step();
`ifdef MEM_STAGE_TIMEOUT_EN
    check("to.err", mem_err, 1'b1);
    check("to.valid", mem_asm.valid, 1'b0);
    check("to.req", dmem_req, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    check("to.err_pulse", mem_err, 1'b0);
    check("to.late_ack", mem_asm.valid, 1'b0);
    ex_mem = mk(OP_LD, 3'd2, 32'h0000_6000, 32'h0, 32'h0);
    step();
    ex_mem.valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_ack = 1'b0;
    check("to.ack_wins_err", mem_err, 1'b0);
    check("to.ack_wins_valid", mem_asm.valid, 1'b1);
`else
    repeat (4) step();
    check("noto.req", dmem_req, 1'b1);
    check("noto.err", mem_err, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_ack = 1'b0;
    check("noto.valid", mem_asm.valid, 1'b1);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 9) != 0);
      next_rdy   = ($urandom_range(0, 3) != 0);
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      ex_mem     = rand_op();
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max BUSY cycles without dmem_ack before abort (used only under MEM_STAGE_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 en  in  1  stage enable.
REQ-005 next_rdy  in  1  asm stage ready to accept.
REQ-006 ex_mem  in  core::ex_mem_t  execute-stage pipeline register (de_inst, pc, rs1_value, rs2_value, ex_result, ex_addr, valid).
REQ-007 dmem_req  out  1  data memory request, held until ack.
REQ-008 dmem_we  out  1  1 = store, 0 = load.
REQ-009 dmem_addr  out  32  word-aligned address, ex_addr with [1:0] cleared.
REQ-010 dmem_wdata  out  32  store data, lane-shifted.
REQ-011 dmem_be  out  4  byte enables.
REQ-012 dmem_ack  in  1  request complete; dmem_rdata valid same cycle.
REQ-013 dmem_rdata  in  32  raw load word.
REQ-014 mem_asm  out  core::mem_asm_t  registered pipeline register to asm stage.
REQ-015 mem_err  out  1  one-cycle bus timeout pulse.
REQ-016 rdy  out  1  stage accepts ex_mem this cycle.

Function
REQ-017 States: IDLE, BUSY, DONE; rdy = en && next_rdy && state==IDLE.
REQ-018 IDLE, rdy, ex_mem.valid, opcode load/store: latch ex_mem, go BUSY, mem_asm.valid <= 0 (bubble).
REQ-019 IDLE, next_rdy, otherwise: mem_asm <= ex_mem fields, mem_result = 0, valid = en && ex_mem.valid; 1-cycle latency.
REQ-020 IDLE, next_rdy low: mem_asm holds.
REQ-021 BUSY: dmem_req = 1; addr/we/wdata/be stable from latched op until ack.
REQ-022 BUSY, dmem_ack, next_rdy: mem_asm <= latched op, mem_result = dmem_rdata (store: 0), valid = 1; go IDLE.
REQ-023 BUSY, dmem_ack, next_rdy low: capture rdata, go DONE; dmem_req drops next cycle.
REQ-024 DONE: dmem_req = 0; on next_rdy emit as REQ-022, go IDLE.
REQ-025 Byte enables: sb 4'b0001 << ex_addr[1:0]; sh 4'b0011 << {ex_addr[1],1'b0}; sw 4'b1111; loads 4'b1111.
REQ-026 dmem_wdata = rs2_value << (ex_addr[1:0]*8); no misalignment trap, lanes beyond bit 31 dropped.
REQ-027 mem_result is raw word; shifting and sign extension are the asm stage's job.
REQ-028 dmem_ack outside BUSY ignored.

Reset
REQ-029 rst: state IDLE, mem_asm = core::mem_asm_rst, dmem_req/dmem_we/mem_err = 0, dmem_be = 0, timeout counter 0.
REQ-030 rst in BUSY/DONE abandons op; dmem_req low from next cycle; no mem_asm emitted.

Configuration
REQ-031 MEM_STAGE_TIMEOUT_EN defined: counter increments each BUSY cycle without ack; at TIMEOUT_CYCLES, go IDLE, dmem_req low, mem_asm.valid <= 0, mem_err = 1 one cycle.
REQ-032 MEM_STAGE_TIMEOUT_EN undefined: BUSY waits indefinitely; mem_err tied 0; no counter.
REQ-033 Ack in same cycle counter reaches limit: ack wins, no error.

Verification
REQ-034 addi valid, next_rdy=1 -> mem_asm.valid=1, ex_result passed, next cycle, no dmem_req.
REQ-035 lw ex_addr=0x1006, ack after 3 cycles, rdata=0xAABBCCDD -> dmem_addr=0x1004, be=4'b1111, rdy=0 during BUSY, mem_result=0xAABBCCDD.
REQ-036 sb ex_addr=0x2003, rs2=0x12 -> be=4'b1000, wdata=0x12000000, we=1.
REQ-037 lh ack with next_rdy=0 for 2 cycles -> DONE, req drops, mem_asm emitted when next_rdy rises.
REQ-038 With MEM_STAGE_TIMEOUT_EN, no ack for 16 cycles -> mem_err pulse, valid=0, IDLE; late ack ignored; rst mid-BUSY -> req=0 next cycle.
